// File: rtl/lr35902_int_ctrl.sv
// ============================================================================
// Module      : lr35902_int_ctrl
// Description : LR35902 interrupt controller with edge-captured IF, IE, CPU
//               register access and fixed-priority vectored dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr35902_int_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       adr,
   input  logic       read,
   input  logic       write,
   output logic [7:0] dout,
   input  logic [4:0] irq_in,
   output logic       int_req,
   input  logic       int_ack,
   output logic [7:0] int_vec
);

   logic [4:0] r_if;
   logic [7:0] r_ie;
   logic [4:0] r_prev_in;
   logic       r_pwrite;
   logic       r_wr_discard;

   logic [4:0] w_pend;
   logic [4:0] w_win_oh;
   logic [2:0] w_win_idx;
   logic [4:0] w_edge;
   logic       w_commit;
   logic [4:0] w_if_nxt;

   assign w_pend   = r_if & r_ie[4:0];
   assign w_win_oh = w_pend & (~w_pend + 5'd1);
   assign w_edge   = irq_in & ~r_prev_in;
   assign w_commit = r_pwrite & ~write & ~r_wr_discard;
   assign int_req  = |w_pend;

   always_comb begin
      w_win_idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (w_pend[i]) w_win_idx = 3'(i);
      end
   end

   // Write first, then ack clear, then edge set: a fresh edge is never lost.
   always_comb begin
      w_if_nxt = r_if;
      if (w_commit && !adr) w_if_nxt = din[4:0];
      if (int_ack) w_if_nxt = w_if_nxt & ~w_win_oh;
      w_if_nxt = w_if_nxt | w_edge;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if         <= 5'd0;
         r_ie         <= 8'd0;
         r_prev_in    <= 5'd0;
         r_pwrite     <= 1'b0;
         r_wr_discard <= write;
         dout         <= 8'd0;
         int_vec      <= 8'd0;
      end else begin
         r_if      <= w_if_nxt;
         r_prev_in <= irq_in;
         r_pwrite  <= write;
         // A write interrupted by reset stays blocked until the strobe drops.
         if (!write) r_wr_discard <= 1'b0;
         if (w_commit && adr) r_ie <= din;
         if (read) dout <= adr ? r_ie : {3'b111, r_if};
         if (int_ack) int_vec <= (|w_pend) ? (8'h40 + {2'b00, w_win_idx, 3'b000}) : 8'h00;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lr35902_int_ctrl.sv
// ============================================================================
// Module      : tb_lr35902_int_ctrl
// Description : Directed and randomized self-checking bench for lr35902_int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lr35902_int_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = 8'd0;
   logic       adr = 1'b0;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [7:0] dout;
   logic [4:0] irq_in = 5'd0;
   logic       int_req;
   logic       int_ack = 1'b0;
   logic [7:0] int_vec;

   int n_checks = 0;
   int n_fail = 0;

   // Reference state
   logic [4:0] m_if = 5'd0;
   logic [7:0] m_ie = 8'd0;
   logic [4:0] m_prev = 5'd0;
   logic       m_wr_prev = 1'b0;
   logic       m_tainted = 1'b0;
   logic [7:0] m_dout = 8'd0;
   logic [7:0] m_vec = 8'd0;

   lr35902_int_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .adr     (adr),
      .read    (read),
      .write   (write),
      .dout    (dout),
      .irq_in  (irq_in),
      .int_req (int_req),
      .int_ack (int_ack),
      .int_vec (int_vec)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [4:0] old_if;
      logic [7:0] old_ie;
      int         winner;
      old_if = m_if;
      old_ie = m_ie;
      if (reset) begin
         m_if = 0; m_ie = 0; m_prev = 0; m_wr_prev = 0; m_dout = 0; m_vec = 0;
         m_tainted = write;
      end else begin
         winner = -1;
         for (int i = 0; i < 5; i++)
            if (winner < 0 && old_if[i] && old_ie[i]) winner = i;
         if (m_wr_prev && !write && !m_tainted) begin
            if (adr) m_ie = din;
            else     m_if = din[4:0];
         end
         if (int_ack) begin
            if (winner >= 0) begin
               m_if[winner] = 1'b0;
               m_vec = 8'(64 + 8 * winner);
            end else begin
               m_vec = 8'h00;
            end
         end
         for (int i = 0; i < 5; i++)
            if (irq_in[i] && !m_prev[i]) m_if[i] = 1'b1;
         if (read) m_dout = adr ? old_ie : {3'b111, old_if};
         m_prev    = irq_in;
         m_wr_prev = write;
         if (!write) m_tainted = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_val("dout", dout, m_dout);
      check_val("int_vec", int_vec, m_vec);
      check_val("int_req", {7'd0, int_req}, {7'd0, |(m_if & m_ie[4:0])});
   endtask

   task automatic cpu_write(input logic a, input logic [7:0] d);
      adr = a; din = d; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
   endtask

   task automatic cpu_read(input logic a);
      adr = a; read = 1'b1;
      tick();
      read = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick();
      check_val("reset_dout", dout, 8'h00);
      check_val("reset_vec", int_vec, 8'h00);
      check_val("reset_req", {7'd0, int_req}, 8'h00);
      reset = 1'b0;
      tick();

      // Single-cycle serial pulse is captured
      cpu_write(1'b1, 8'h1F);
      irq_in = 5'h08; tick(); irq_in = 5'h00; tick();
      check_val("pulse_req", {7'd0, int_req}, 8'h01);
      cpu_read(1'b0);
      check_val("pulse_if", dout, 8'hE8);

      // Two acks in priority order
      cpu_write(1'b0, 8'h0C);
      cpu_write(1'b1, 8'h0C);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      check_val("ack1_vec", int_vec, 8'h50);
      check_val("ack1_req", {7'd0, int_req}, 8'h01);
      cpu_read(1'b0);
      check_val("ack1_if", dout, 8'hE8);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      check_val("ack2_vec", int_vec, 8'h58);
      check_val("ack2_req", {7'd0, int_req}, 8'h00);

      // Cancelled dispatch
      cpu_write(1'b0, 8'h01);
      cpu_write(1'b1, 8'h00);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      check_val("cancel_vec", int_vec, 8'h00);
      check_val("cancel_req", {7'd0, int_req}, 8'h00);
      cpu_read(1'b0);
      check_val("cancel_if", dout, 8'hE1);

      // Ack and new edge on the same bit in the same cycle
      cpu_write(1'b0, 8'h04);
      cpu_write(1'b1, 8'h04);
      int_ack = 1'b1; irq_in = 5'h04; tick(); int_ack = 1'b0;
      check_val("ackedge_vec", int_vec, 8'h50);
      cpu_read(1'b0);
      check_val("ackedge_if", dout, 8'hE4);
      irq_in = 5'h00; tick();

      // Held source sets once; CPU clear sticks
      cpu_write(1'b0, 8'h00);
      irq_in = 5'h01;
      tick(); tick();
      cpu_read(1'b0);
      check_val("hold_set", dout, 8'hE1);
      cpu_write(1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cpu_read(1'b0);
         check_val("hold_clr", dout, 8'hE0);
      end
      irq_in = 5'h00; tick();

      // Upper IE bits stored but inert
      cpu_write(1'b1, 8'hE0);
      cpu_read(1'b1);
      check_val("ie_hi_read", dout, 8'hE0);
      cpu_write(1'b0, 8'h1F);
      check_val("ie_hi_req", {7'd0, int_req}, 8'h00);

      // Write interrupted by reset is discarded
      adr = 1'b1; din = 8'h1F; write = 1'b1; tick();
      reset = 1'b1; tick();
      reset = 1'b0; tick(); tick();
      write = 1'b0; tick();
      cpu_read(1'b1);
      check_val("rst_wr_discard", dout, 8'h00);

      // Source held through reset is captured afterwards
      irq_in = 5'h10; reset = 1'b1; tick(); tick();
      reset = 1'b0; tick();
      cpu_read(1'b0);
      check_val("rst_hold_if", dout, 8'hF0);
      irq_in = 5'h00;

      // Randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 2) == 0) write = ~write;
         din     = 8'($urandom);
         adr     = 1'($urandom);
         read    = 1'($urandom);
         int_ack = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lr35902_int_ctrl.md
LR35902_INT_CTRL -- requirements
Module: lr35902_int_ctrl

Interface
REQ-001: clk  in  1  system clock; all state updates on rising edge.
REQ-002: reset  in  1  synchronous, active-high reset.
REQ-003: din  in  8  CPU write data.
REQ-004: adr  in  1  register select; 0 = IF (FF0F), 1 = IE (FFFF).
REQ-005: read  in  1  CPU read strobe, level.
REQ-006: write  in  1  CPU write strobe, level.
REQ-007: dout  out  8  registered CPU read data.
REQ-008: irq_in  in  5  interrupt sources: bit0 vblank, bit1 stat, bit2 timer, bit3 serial (irq of the serial block), bit4 joypad.
REQ-009: int_req  out  1  interrupt pending to CPU, level.
REQ-010: int_ack  in  1  CPU dispatch acknowledge, single-cycle pulse.
REQ-011: int_vec  out  8  registered dispatch vector.

Function
REQ-012: The block SHALL hold registers IF[4:0], IE[7:0], prev_in[4:0], pwrite and int_vec[7:0].
REQ-013: The block SHALL set IF[n] on every cycle where irq_in[n]=1 and prev_in[n]=0, and SHALL update prev_in <= irq_in every cycle.
REQ-014: A source held high SHALL set IF[n] only once per rising edge, and a one-cycle pulse SHALL always be captured.
REQ-015: Writes SHALL commit on the cycle where pwrite=1 and write=0 (write falling edge), using din and adr sampled that cycle, and pwrite <= write every cycle.
REQ-016: An IF write SHALL load IF <= din[4:0], and din[7:5] SHALL be ignored.
REQ-017: An IE write SHALL load all 8 bits of IE.
REQ-018: On each cycle with read=1, dout SHALL load {3'b111, IF} when adr=0 and IE when adr=1.
REQ-019: dout SHALL hold its value while read=0.
REQ-020: int_req SHALL equal |(IF & IE[4:0]), combinationally from registered state.
REQ-021: Priority SHALL be fixed: lowest pending-and-enabled bit index wins (bit0 highest).
REQ-022: On a cycle with int_ack=1, the block SHALL load int_vec <= 8'h40 + 8*n for winning index n and clear IF[n].
REQ-023: The vector and IF[n] clear SHALL both be visible on the next cycle (latency 1).
REQ-024: On int_ack with nothing pending and enabled, the block SHALL load int_vec <= 8'h00 and leave IF unchanged (cancelled dispatch).
REQ-025: int_vec SHALL hold its value between acks.
REQ-026: Same-cycle conflicts SHALL resolve in this priority order, highest first: edge set of IF[n], then ack clear of IF[n], then CPU IF write. A new event on the same bit therefore SHALL never be lost.
REQ-027: The ack winner SHALL be computed from IF/IE values before any same-cycle write or edge set.
REQ-028: IE[7:5] SHALL be stored and readable but SHALL NOT affect int_req or priority.

Reset
REQ-029: On reset=1 at a clock edge, the block SHALL load IF=0, IE=0, prev_in=0, pwrite=0, dout=0, int_vec=0; int_req is therefore 0.
REQ-030: Reset SHALL override every same-cycle event (edge, write, ack).
REQ-031: A source held high through reset SHALL set its IF bit on the first cycle after reset deasserts.
REQ-032: Reset asserted mid-write (write high) SHALL discard that write; no commit occurs when write later falls.

Verification
REQ-033: Reset, then IE write 8'h1F, pulse irq_in[3] one cycle -> IF=5'h08, int_req=1, read adr=0 gives dout=8'hE8.
REQ-034: IF=5'h0C, IE=8'h0C, int_ack pulse -> next cycle int_vec=8'h50, IF=5'h08, int_req=1; second ack -> int_vec=8'h58, IF=0, int_req=0.
REQ-035: IF=5'h01, IE=8'h00, int_ack -> int_vec=8'h00, IF unchanged at 5'h01, int_req=0.
REQ-036: IF=5'h04, IE=8'h04, int_ack and irq_in[2] rising edge in the same cycle -> int_vec=8'h50, IF[2]=1 afterwards.
REQ-037: Hold irq_in[0]=1 for 10 cycles; CPU writes IF=0 mid-hold -> IF[0] set once only and stays 0 after the write until the next rising edge.
REQ-038: Write IE=8'hE0 -> read adr=1 gives 8'hE0; set IF=5'h1F -> int_req=0.
